// File: rtl/hp_mul_pkg.sv
// hp_mul_pkg: shared constants and types for the bfloat16 multiplier.
// Holds the default field widths, the exponent bias helper, the bit
// positions of the class and exception vectors and the canonical qNaN.
package hp_mul_pkg;

   // Default bfloat16 field widths: 1 sign, 8 exponent, 7 fraction bits.
   localparam int HP_NEXP = 8;
   localparam int HP_NSIG = 7;

   // Bit positions inside bfFlags (one-hot class of the product).
   localparam int CLS_NORMAL    = 0;
   localparam int CLS_SUBNORMAL = 1;
   localparam int CLS_ZERO      = 2;
   localparam int CLS_INF       = 3;
   localparam int CLS_QNAN      = 4;
   localparam int CLS_SNAN      = 5;

   // Bit positions inside the exception vector.
   localparam int EXC_INVALID   = 0;
   localparam int EXC_DIVZERO   = 1;
   localparam int EXC_OVERFLOW  = 2;
   localparam int EXC_UNDERFLOW = 3;
   localparam int EXC_INEXACT   = 4;

   // Canonical quiet NaN for the default bfloat16 format.
   localparam logic [15:0] QNAN_BF16 = 16'h7FC0;

   // Per-operand classification used to pick the special-case result.
   typedef struct packed {
      logic is_nan;
      logic is_snan;
      logic is_inf;
      logic is_zero;
   } op_class_t;

   // Which source feeds the product register.
   typedef enum logic [1:0] {
      SEL_FINITE,
      SEL_QNAN,
      SEL_INF,
      SEL_ZERO
   } result_sel_t;

   // Exponent bias for an exponent field of the given width.
   function automatic int fp_bias(input int nexp);
      return (1 << (nexp - 1)) - 1;
   endfunction

endpackage

// File: rtl/fp_round.sv
// fp_round: rounds a normalised wide significand to a packed float.
// The significand arrives with its leading one in the top bit and the
// biased exponent of that leading one. Rounding is nearest-even. Tininess
// is judged after rounding with an unbounded exponent range.
// HP_MUL_SUBNORMAL_EN selects gradual underflow; without it tiny results
// are flushed to signed zero.
module fp_round
   import hp_mul_pkg::*;
#(
   parameter int NEXP = HP_NEXP,
   parameter int NSIG = HP_NSIG
)
(
   input  logic                   sign,
   input  logic signed [NEXP+2:0] expo,
   input  logic [2*NSIG+1:0]      sig,
   output logic [NEXP+NSIG:0]     res,
   output logic                   overflow,
   output logic                   underflow,
   output logic                   inexact
);

   localparam int W  = NEXP + NSIG + 1;
   localparam int PW = 2 * NSIG + 2;
   localparam int EW = NEXP + 3;
   localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << NEXP) - 1);
   localparam logic signed [EW-1:0] EXP_ONE = EW'(1);

   // Normal-precision rounding results (also used for the tininess test)
   logic [NSIG:0]          n_mant;
   logic                   n_grd;
   logic                   n_stk;
   logic                   n_up;
   logic [NSIG+1:0]        n_sum;
   logic                   n_carry;
   logic [NSIG-1:0]        n_frac;
   logic signed [EW-1:0]   n_exp;
   logic                   n_inexact;
   logic                   tiny;

   // Round at full precision; a carry-out bumps the exponent by one
   always_comb begin
      n_mant    = sig[PW-1:NSIG+1];
      n_grd     = sig[NSIG];
      n_stk     = |sig[NSIG-1:0];
      n_up      = n_grd & (n_stk | n_mant[0]);
      n_sum     = {1'b0, n_mant} + {{(NSIG+1){1'b0}}, n_up};
      n_carry   = n_sum[NSIG+1];
      n_frac    = n_carry ? n_sum[NSIG:1] : n_sum[NSIG-1:0];
      n_exp     = expo + $signed({{(EW-1){1'b0}}, n_carry});
      n_inexact = n_grd | n_stk;
      tiny      = (n_exp < EXP_ONE);
   end

`ifdef HP_MUL_SUBNORMAL_EN
   localparam int SHW = $clog2(PW + 2);
   localparam logic signed [EW-1:0] SH_CLAMP = EW'(PW + 1);

   logic signed [EW-1:0]   sh_raw;
   logic [SHW-1:0]         sh;
   logic [PW-1:0]          d_sig;
   logic                   d_lost;
   logic [NSIG:0]          d_mant;
   logic                   d_grd;
   logic                   d_stk;
   logic                   d_up;
   logic [NSIG:0]          d_sum;
   logic                   d_inexact;

   // Denormalise by shifting right to the minimum exponent, keeping a sticky
   always_comb begin
      sh_raw = EXP_ONE - expo;
      if (sh_raw > SH_CLAMP) begin
         sh = SHW'(PW + 1);
      end else begin
         sh = sh_raw[SHW-1:0];
      end
      d_sig     = sig >> sh;
      d_lost    = |(sig & ~({PW{1'b1}} << sh));
      d_mant    = d_sig[PW-1:NSIG+1];
      d_grd     = d_sig[NSIG];
      d_stk     = (|d_sig[NSIG-1:0]) | d_lost;
      d_up      = d_grd & (d_stk | d_mant[0]);
      // top bit of d_mant is clear, so a carry lands in the hidden bit
      // and turns the result into the smallest normal number
      d_sum     = d_mant + {{NSIG{1'b0}}, d_up};
      d_inexact = d_grd | d_stk;
   end
`endif

   // Choose between normal, overflowed and tiny results
   always_comb begin
      res       = {sign, n_exp[NEXP-1:0], n_frac};
      overflow  = 1'b0;
      underflow = 1'b0;
      inexact   = n_inexact;
      if (tiny) begin
`ifdef HP_MUL_SUBNORMAL_EN
         res       = {sign, {(NEXP-1){1'b0}}, d_sum};
         underflow = d_inexact;
         inexact   = d_inexact;
`else
         res       = {sign, {(W-1){1'b0}}};
         underflow = 1'b1;
         inexact   = 1'b1;
`endif
      end else if (n_exp >= EXP_MAX) begin
         res      = {sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
         overflow = 1'b1;
         inexact  = 1'b1;
      end
   end

endmodule

// File: rtl/hp_mul.sv
// hp_mul: bfloat16 multiplier with one register stage on the outputs.
// Operands are classified inline; NaN/Inf/zero take a bypass, finite
// operands go through a full-width product, leading-zero normalisation
// and the fp_round sub-module. Define HP_MUL_SUBNORMAL_EN for gradual
// underflow; otherwise subnormal inputs and tiny results flush to zero.
module hp_mul
   import hp_mul_pkg::*;
#(
   parameter int NEXP = HP_NEXP,
   parameter int NSIG = HP_NSIG
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NEXP+NSIG:0]   a,
   input  logic [NEXP+NSIG:0]   b,
   output logic [NEXP+NSIG:0]   p,
   output logic [5:0]           bfFlags,
   output logic [4:0]           exception
);

   localparam int W    = NEXP + NSIG + 1;
   localparam int PW   = 2 * NSIG + 2;
   localparam int EW   = NEXP + 3;
   localparam int LZW  = $clog2(PW + 1);
   localparam int BIAS = fp_bias(NEXP);
   localparam logic [W-1:0] QNAN = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};

   logic [W-1:0]        ops     [2];
   op_class_t           cls     [2];
   logic [NSIG:0]       sig     [2];
   logic [NEXP-1:0]     eff_exp [2];

   assign ops[0] = a;
   assign ops[1] = b;

   // Per-operand field decode and classification
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
         logic [NEXP-1:0] e;
         logic [NSIG-1:0] f;
         logic            exp_ones;
         logic            exp_zero;
         logic            frac_nz;
         logic            zero_val;

         assign e        = ops[gi][W-2:NSIG];
         assign f        = ops[gi][NSIG-1:0];
         assign exp_ones = &e;
         assign exp_zero = ~(|e);
         assign frac_nz  = |f;
`ifdef HP_MUL_SUBNORMAL_EN
         assign zero_val = exp_zero & ~frac_nz;
`else
         // flush-to-zero: any subnormal encoding is treated as zero
         assign zero_val = exp_zero;
`endif
         assign cls[gi] = '{
            is_nan:  exp_ones & frac_nz,
            is_snan: exp_ones & frac_nz & ~f[NSIG-1],
            is_inf:  exp_ones & ~frac_nz,
            is_zero: zero_val
         };
         // subnormals carry a zero hidden bit and the minimum exponent
         assign sig[gi]     = {~exp_zero, f};
         assign eff_exp[gi] = exp_zero ? NEXP'(1) : e;
      end
   endgenerate

   logic        res_sign;
   result_sel_t sel;
   logic        inv;

   assign res_sign = ops[0][W-1] ^ ops[1][W-1];

   // Special-case priority: NaN, Inf x 0, Inf, zero, else finite
   always_comb begin
      sel = SEL_FINITE;
      inv = 1'b0;
      if (cls[0].is_nan | cls[1].is_nan) begin
         sel = SEL_QNAN;
         inv = cls[0].is_snan | cls[1].is_snan;
      end else if ((cls[0].is_inf & cls[1].is_zero) | (cls[0].is_zero & cls[1].is_inf)) begin
         sel = SEL_QNAN;
         inv = 1'b1;
      end else if (cls[0].is_inf | cls[1].is_inf) begin
         sel = SEL_INF;
      end else if (cls[0].is_zero | cls[1].is_zero) begin
         sel = SEL_ZERO;
      end
   end

   logic [PW-1:0]        prod;
   logic [LZW-1:0]       lz;
   logic [PW-1:0]        norm;
   logic signed [EW-1:0] be;

   assign prod = PW'(sig[0]) * PW'(sig[1]);

   // Leading-zero count of the raw product
   always_comb begin
      logic found;
      lz    = '0;
      found = 1'b0;
      for (int i = PW - 1; i >= 0; i--) begin
         if (!found) begin
            if (prod[i]) begin
               found = 1'b1;
            end else begin
               lz = lz + LZW'(1);
            end
         end
      end
   end

   // Leading one to the top; exponent of that one, biased
   assign norm = prod << lz;
   assign be   = EW'(eff_exp[0]) + EW'(eff_exp[1]) - EW'(BIAS) + EW'(1) - EW'(lz);

   logic [W-1:0] rnd_res;
   logic         rnd_of;
   logic         rnd_uf;
   logic         rnd_nx;

   fp_round #(
      .NEXP (NEXP),
      .NSIG (NSIG)
   ) u_round (
      .sign      (res_sign),
      .expo      (be),
      .sig       (norm),
      .res       (rnd_res),
      .overflow  (rnd_of),
      .underflow (rnd_uf),
      .inexact   (rnd_nx)
   );

   logic [W-1:0] p_next;
   logic [4:0]   exc_next;
   logic [5:0]   flags_next;

   // Select the product and its exception flags
   always_comb begin
      p_next   = rnd_res;
      exc_next = '0;
      case (sel)
         SEL_QNAN: begin
            p_next                = QNAN;
            exc_next[EXC_INVALID] = inv;
         end
         SEL_INF:  p_next = {res_sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
         SEL_ZERO: p_next = {res_sign, {(W-1){1'b0}}};
         default: begin
            p_next                  = rnd_res;
            exc_next[EXC_OVERFLOW]  = rnd_of;
            exc_next[EXC_UNDERFLOW] = rnd_uf;
            exc_next[EXC_INEXACT]   = rnd_nx;
         end
      endcase
   end

   // Classify the final product; output NaNs are always quiet
   always_comb begin
      flags_next = '0;
      if (&p_next[W-2:NSIG]) begin
         if (|p_next[NSIG-1:0]) begin
            flags_next[CLS_QNAN] = 1'b1;
         end else begin
            flags_next[CLS_INF] = 1'b1;
         end
      end else if (~(|p_next[W-2:NSIG])) begin
         if (|p_next[NSIG-1:0]) begin
            flags_next[CLS_SUBNORMAL] = 1'b1;
         end else begin
            flags_next[CLS_ZERO] = 1'b1;
         end
      end else begin
         flags_next[CLS_NORMAL] = 1'b1;
      end
   end

   // Output register; reset shows a positive zero with no exceptions
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p         <= '0;
         bfFlags   <= 6'b000100;
         exception <= '0;
      end else begin
         p         <= p_next;
         bfFlags   <= flags_next;
         exception <= exc_next;
      end
   end

endmodule

// File: tb/tb_hp_mul.sv
// tb_hp_mul: directed and random checks of hp_mul against a real-number
// reference model of bfloat16 multiplication with nearest-even rounding.
module tb_hp_mul;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] a = 16'h0000;
   logic [15:0] b = 16'h0000;
   logic [15:0] p;
   logic [5:0]  bfFlags;
   logic [4:0]  exception;

   int compared   = 0;
   int mismatched = 0;

`ifdef HP_MUL_SUBNORMAL_EN
   localparam bit SUB = 1'b1;
`else
   localparam bit SUB = 1'b0;
`endif

   hp_mul dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a),
      .b         (b),
      .p         (p),
      .bfFlags   (bfFlags),
      .exception (exception)
   );

   always #5 clk = ~clk;

   function automatic real pow2(input int e);
      real r;
      r = 1.0;
      if (e >= 0) begin
         for (int i = 0; i < e; i++) r = r * 2.0;
      end else begin
         for (int i = 0; i < -e; i++) r = r / 2.0;
      end
      return r;
   endfunction

   function automatic int ilog2(input real v);
      int e;
      e = 0;
      while (v >= pow2(e + 1)) e++;
      while (v < pow2(e)) e--;
      return e;
   endfunction

   function automatic real rne(input real n);
      real fl;
      real d;
      fl = $floor(n);
      d  = n - fl;
      if (d > 0.5) return fl + 1.0;
      if ((d == 0.5) && (($rtoi(fl) % 2) == 1)) return fl + 1.0;
      return fl;
   endfunction

   // magnitude of a finite encoding
   function automatic real mag(input logic [15:0] x);
      int f;
      f = int'(x[6:0]);
      if (x[14:7] == 8'h00) return f * pow2(-133);
      return (128 + f) * pow2(int'(x[14:7]) - 134);
   endfunction

   // encoding (without sign) of an exactly representable magnitude
   function automatic logic [14:0] enc_mag(input real rv);
      int e2;
      int m;
      if (rv == 0.0) return 15'h0000;
      if (rv < pow2(-126)) return 15'($rtoi(rv / pow2(-133)));
      e2 = ilog2(rv);
      m  = $rtoi(rv / pow2(e2 - 7)) - 128;
      return {8'(e2 + 127), 7'(m)};
   endfunction

   function automatic logic [5:0] cls_of(input logic [15:0] v);
      if (v[14:7] == 8'hFF) return (v[6:0] != 0) ? 6'b010000 : 6'b001000;
      if (v[14:7] == 8'h00) return (v[6:0] != 0) ? 6'b000010 : 6'b000100;
      return 6'b000001;
   endfunction

   task automatic ref_mul(input logic [15:0] x, input logic [15:0] y,
                          output logic [15:0] rp, output logic [4:0] rexc);
      logic sg;
      bit   xn, yn, xs, ys, xi, yi, xz, yz, tiny, inx;
      real  v, q, ru, rv;
      int   e;
      sg   = x[15] ^ y[15];
      rexc = 5'b00000;
      xn = (x[14:7] == 8'hFF) && (x[6:0] != 0);
      yn = (y[14:7] == 8'hFF) && (y[6:0] != 0);
      xs = xn && !x[6];
      ys = yn && !y[6];
      xi = (x[14:7] == 8'hFF) && (x[6:0] == 0);
      yi = (y[14:7] == 8'hFF) && (y[6:0] == 0);
      xz = (x[14:7] == 8'h00) && ((x[6:0] == 0) || !SUB);
      yz = (y[14:7] == 8'h00) && ((y[6:0] == 0) || !SUB);
      if (xn || yn) begin
         rp      = 16'h7FC0;
         rexc[0] = xs || ys;
      end else if ((xi && yz) || (xz && yi)) begin
         rp      = 16'h7FC0;
         rexc[0] = 1'b1;
      end else if (xi || yi) begin
         rp = {sg, 8'hFF, 7'h00};
      end else if (xz || yz) begin
         rp = {sg, 15'h0000};
      end else begin
         v    = mag(x) * mag(y);
         e    = ilog2(v);
         ru   = rne(v / pow2(e - 7)) * pow2(e - 7);
         tiny = (ru < pow2(-126));
         q    = SUB ? pow2(((e < -126) ? -126 : e) - 7) : pow2(e - 7);
         rv   = rne(v / q) * q;
         inx  = (rv != v);
         if (!SUB && tiny) begin
            rp      = {sg, 15'h0000};
            rexc[3] = 1'b1;
            rexc[4] = 1'b1;
         end else if (rv >= pow2(128)) begin
            rp      = {sg, 8'hFF, 7'h00};
            rexc[2] = 1'b1;
            rexc[4] = 1'b1;
         end else begin
            rp      = {sg, enc_mag(rv)};
            rexc[3] = tiny && inx;
            rexc[4] = inx;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic step(input logic [15:0] x, input logic [15:0] y, input string tag);
      logic [15:0] ep;
      logic [4:0]  ee;
      ref_mul(x, y, ep, ee);
      a = x;
      b = y;
      @(posedge clk);
      #1;
      $display("txn %s a=%h b=%h p=%h cls=%b exc=%b", tag, x, y, p, bfFlags, exception);
      chk({tag, ".p"}, p, ep);
      chk({tag, ".cls"}, {10'h000, bfFlags}, {10'h000, cls_of(ep)});
      chk({tag, ".exc"}, {11'h000, exception}, {11'h000, ee});
   endtask

   function automatic logic [15:0] rand_op(input int mode);
      logic [15:0] r;
      logic [7:0]  e;
      logic [15:0] specials [8];
      specials = '{16'h0000, 16'h8000, 16'h7F80, 16'hFF80,
                   16'h7FC0, 16'h7F81, 16'h0001, 16'h8080};
      r = 16'($urandom());
      case (mode)
         1:       e = 8'($urandom_range(0, 75));
         2:       e = 8'($urandom_range(180, 200));
         3:       e = 8'($urandom_range(110, 140));
         4:       return specials[$urandom_range(0, 7)];
         default: e = r[14:7];
      endcase
      return {r[15], e, r[6:0]};
   endfunction

   initial begin
      int mode;
      // reset state
      #12;
      chk("rst.p", p, 16'h0000);
      chk("rst.cls", {10'h000, bfFlags}, 16'h0004);
      chk("rst.exc", {11'h000, exception}, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;

      // directed cases
      step(16'h0000, 16'h0000, "zero_x_zero");
      step(16'h7F80, 16'h0000, "inf_x_zero");
      step(16'h7FC0, 16'h3F80, "qnan_x_one");
      step(16'h7F81, 16'h3F80, "snan_x_one");
      step(16'h3F80, 16'h4000, "one_x_two");
      step(16'hBF80, 16'h3F80, "neg_one");
      step(16'h3FC0, 16'h3FA0, "1p5_x_1p25");
      step(16'h7F80, 16'h3F80, "inf_x_one");
      step(16'h0040, 16'h3F80, "sub_x_one");
      step(16'h7F00, 16'h7F00, "overflow");
      step(16'h0001, 16'h0001, "min_sub_sq");
      step(16'h3F81, 16'h3F81, "round_down");
      step(16'h0080, 16'h3F00, "minnorm_half");
      step(16'h3F7F, 16'h0081, "near_minnorm");
      step(16'hFF80, 16'h8000, "ninf_x_nzero");
      step(16'h3F80, 16'h4000, "pre_reset");

      // asynchronous reset in the middle of the stream
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst.p", p, 16'h0000);
      chk("midrst.cls", {10'h000, bfFlags}, 16'h0004);
      chk("midrst.exc", {11'h000, exception}, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;

      // random operand pairs drawn from correlated exponent ranges
      for (int i = 0; i < 400; i++) begin
         mode = $urandom_range(0, 4);
         step(rand_op(mode), rand_op(mode), $sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
